dot_op_sequencer: RTL and testbench



---
 rtl/dot_op_sequencer.sv | 151 +++++++++++++++
 tb/tb_dot_op_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dot_op_sequencer.sv
// Pin-level sequencer for the 3-bit multiply/divide operator: serial operand
// capture, 3-step shift-add multiply or restoring divide, registered result/status.
module dot_op_sequencer (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned OpW      = 3;
  localparam int unsigned ResW     = 6;
  localparam int unsigned StepW    = 2;
  localparam int unsigned StepLast = 2;

  typedef enum logic [1:0] {IDLE, OPB, EXEC, DONE} state_t;

  logic             clk;
  logic             rst;
  logic             valid;
  logic             op_code;
  logic [OpW-1:0]   operand;
  logic             unused_pin;

  // Pin unpacking; the operand MSB sits on the lowest-numbered pin.
  assign clk        = io_in[0];
  assign rst        = io_in[1];
  assign valid      = io_in[2];
  assign op_code    = io_in[3];
  assign operand    = {io_in[4], io_in[5], io_in[6]};
  assign unused_pin = io_in[7];

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [OpW-1:0]    op_a_q, op_a_d;
  logic [OpW-1:0]    op_b_q, op_b_d;
  logic              opc_q, opc_d;
  logic [StepW-1:0]  step_q, step_d;
  logic [ResW-1:0]   acc_q, acc_d;
  logic [OpW-1:0]    quo_q, quo_d;
  logic [OpW-1:0]    rem_q, rem_d;
  logic [ResW-1:0]   result_q, result_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              rise;
  logic [OpW:0]      partial;
  logic              div_ge;
  logic [OpW-1:0]    rem_nx;
  logic [OpW-1:0]    quo_nx;
  logic [ResW-1:0]   mul_add;
  logic [ResW-1:0]   acc_nx;

  assign rise = valid & ~valid_q;

  // One iteration of the shared datapath for the current step.
  assign partial = {rem_q, op_a_q[StepW'(StepLast) - step_q]};
  assign div_ge  = partial >= {1'b0, op_b_q};
  assign rem_nx  = div_ge ? OpW'(partial - {1'b0, op_b_q}) : partial[OpW-1:0];
  assign quo_nx  = {quo_q[OpW-2:0], div_ge};
  assign mul_add = op_b_q[step_q] ? (ResW'(op_a_q) << step_q) : '0;
  assign acc_nx  = acc_q + mul_add;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    opc_d    = opc_q;
    step_d   = step_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
    done_d   = done_q;
    busy_d   = busy_q;

    unique case (state_q)
      IDLE, DONE: begin
        busy_d = 1'b0;
        if (rise) begin
          op_a_d  = operand;
          opc_d   = op_code;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = OPB;
        end
      end
      OPB: begin
        if (rise) begin
          op_b_d  = operand;
          step_d  = '0;
          acc_d   = '0;
          quo_d   = '0;
          rem_d   = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        acc_d  = acc_nx;
        quo_d  = quo_nx;
        rem_d  = rem_nx;
        step_d = step_q + StepW'(1);
        if (step_q == StepW'(StepLast)) begin
          // A zero divisor forces an all-zero quotient and remainder.
          if (opc_q)
            result_d = (op_b_q == '0) ? '0 : {quo_nx, rem_nx};
          else
            result_d = acc_nx;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      opc_q    <= 1'b0;
      step_q   <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      opc_q    <= opc_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Result MSB drives io_out[0].
  assign io_out = {busy_q, done_q,
                   result_q[0], result_q[1], result_q[2],
                   result_q[3], result_q[4], result_q[5]};

endmodule

// File: tb/tb_dot_op_sequencer.sv
// Bench for dot_op_sequencer: arithmetic reference model compared every cycle,
// plus directed literal expectations and randomized operations.
module tb_dot_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       opc = 1'b0;
  logic       spare = 1'b0;
  logic [2:0] operand = 3'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {spare, operand[0], operand[1], operand[2], opc, valid, rst, clk};

  dot_op_sequencer dut (.io_in(io_in), .io_out(io_out));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [5:0] ref_calc(input logic op, input logic [2:0] a, input logic [2:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (!op) return 6'(ia * ib);
    if (ib == 0) return 6'd0;
    return 6'((ia / ib) * 8 + (ia % ib));
  endfunction

  function automatic logic [7:0] pack(input logic [5:0] r, input logic d, input logic b);
    return {b, d, r[0], r[1], r[2], r[3], r[4], r[5]};
  endfunction

  function automatic int res_of(input logic [7:0] io);
    return int'({io[0], io[1], io[2], io[3], io[4], io[5]});
  endfunction

  // Reference model: phase 0 idle, 1 awaiting op_b, 2 computing, 3 result held.
  int         m_ph = 0;
  int         m_left = 0;
  logic       m_vq = 1'b0;
  logic       m_rise;
  logic [2:0] m_a = 3'd0, m_b = 3'd0;
  logic       m_opc = 1'b0;
  logic [5:0] m_res = 6'd0;
  logic       m_done = 1'b0, m_busy = 1'b0;
  logic [7:0] m_exp = 8'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_vq = 1'b0; m_a = 3'd0; m_b = 3'd0; m_opc = 1'b0;
      m_res = 6'd0; m_done = 1'b0; m_busy = 1'b0; m_left = 0;
    end else begin
      m_rise = valid && !m_vq;
      m_vq = valid;
      case (m_ph)
        0, 3: if (m_rise) begin
          m_a = operand; m_opc = opc; m_done = 1'b0; m_busy = 1'b1; m_ph = 1;
        end
        1: if (m_rise) begin
          m_b = operand; m_left = 3; m_ph = 2;
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_res = ref_calc(m_opc, m_a, m_b);
            m_done = 1'b1; m_busy = 1'b0; m_ph = 3;
          end
        end
      endcase
    end
    m_exp = pack(m_res, m_done, m_busy);
  end

  always @(negedge clk) begin
    if (chk_en) check("io_out_vs_model", int'(io_out), int'(m_exp));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic op, input logic [2:0] val);
    valid = 1'b1; opc = op; operand = val;
    step();
    valid = 1'b0;
    step();
  endtask

  // Capture op_b, optionally raise valid mid-computation, then check latency and result.
  task automatic finish_op(input logic [2:0] b, input logic poke, input logic [5:0] expv,
                           input bit pin_model, input string name);
    pulse(1'($urandom), b);
    if (poke) begin
      valid = 1'b1; operand = 3'($urandom); opc = 1'($urandom);
    end
    step();
    valid = 1'b0;
    @(negedge clk);
    check({name, "_done_early"}, int'(io_out[6]), 0);
    check({name, "_busy_exec"}, int'(io_out[7]), 1);
    step();
    @(negedge clk);
    check({name, "_result"}, res_of(io_out), int'(expv));
    check({name, "_done"}, int'(io_out[6]), 1);
    check({name, "_busy_idle"}, int'(io_out[7]), 0);
    if (pin_model) check({name, "_model"}, int'(m_res), int'(expv));
  endtask

  task automatic run_op(input logic op, input logic [2:0] a, input logic [2:0] b,
                        input logic poke, input logic [5:0] expv, input bit pin_model,
                        input string name);
    pulse(op, a);
    finish_op(b, poke, expv, pin_model, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    check("reset_io_out", int'(io_out), 0);
    rst = 1'b0;
    step();

    run_op(1'b0, 3'd5, 3'd3, 1'b0, 6'd15, 1'b1, "mul_5x3");
    check("mul_5x3_pins", int'(io_out), int'(8'b0111_1100));
    run_op(1'b0, 3'd7, 3'd7, 1'b0, 6'd49, 1'b1, "mul_7x7");
    run_op(1'b0, 3'd0, 3'd6, 1'b0, 6'd0,  1'b1, "mul_0x6");
    run_op(1'b1, 3'd7, 3'd3, 1'b0, 6'd17, 1'b1, "div_7_3");
    run_op(1'b1, 3'd3, 3'd5, 1'b0, 6'd3,  1'b1, "div_3_5");
    run_op(1'b1, 3'd6, 3'd6, 1'b0, 6'd8,  1'b1, "div_6_6");
    run_op(1'b1, 3'd5, 3'd0, 1'b0, 6'd0,  1'b1, "div_5_0");

    // Held valid captures only op_a.
    valid = 1'b1; opc = 1'b1; operand = 3'd4;
    repeat (10) step();
    @(negedge clk);
    check("hold_busy", int'(io_out[7]), 1);
    check("hold_done", int'(io_out[6]), 0);
    valid = 1'b0;
    step();
    opc = 1'b1;
    finish_op(3'd2, 1'b0, 6'd16, 1'b1, "div_4_2");

    // Reset during the second computation step.
    pulse(1'b0, 3'd7);
    pulse(1'b0, 3'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_exec", int'(io_out), 0);
    step();
    run_op(1'b0, 3'd2, 3'd3, 1'b1, 6'd6, 1'b1, "mul_2x3_after_rst");

    for (int i = 0; i < 40; i++) begin
      logic       op;
      logic [2:0] a, b;
      op = 1'($urandom);
      a = 3'($urandom);
      b = 3'($urandom);
      spare = 1'($urandom);
      repeat ($urandom_range(0, 2)) step();
      run_op(op, a, b, 1'($urandom), ref_calc(op, a, b), 1'b0, "rand");
    end

    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
